// File: rtl/data_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter_if
// Bundles the three buses around the data-memory arbiter:
//   Core_*  : CPU MEM-stage request, stall and load-return channel
//   Ld_*    : external key/ciphertext loader request, grant and read return
//   Mem_*   : single-port synchronous RAM (read data one cycle after Mem_En)
// Modports:
//   slave  - the arbiter itself (takes requests, drives grants and the RAM)
//   master - the environment (core, loader and RAM model)
// ---------------------------------------------------------------------------
interface data_mem_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              Core_Req;
   logic              Core_WE;
   logic [ADDR_W-1:0] Core_Addr;
   logic [DATA_W-1:0] Core_WData;
   logic              Core_Stall;
   logic [DATA_W-1:0] Core_RData;
   logic              Core_RValid;

   logic              Ld_Req;
   logic              Ld_WE;
   logic              Ld_Lock;
   logic [ADDR_W-1:0] Ld_Addr;
   logic [DATA_W-1:0] Ld_WData;
   logic              Ld_Gnt;
   logic [DATA_W-1:0] Ld_RData;
   logic              Ld_RValid;

   logic              Mem_En;
   logic              Mem_WE;
   logic [ADDR_W-1:0] Mem_Addr;
   logic [DATA_W-1:0] Mem_WData;
   logic [DATA_W-1:0] Mem_RData;

   modport slave (
      input  Core_Req, Core_WE, Core_Addr, Core_WData,
      input  Ld_Req, Ld_WE, Ld_Lock, Ld_Addr, Ld_WData,
      input  Mem_RData,
      output Core_Stall, Core_RData, Core_RValid,
      output Ld_Gnt, Ld_RData, Ld_RValid,
      output Mem_En, Mem_WE, Mem_Addr, Mem_WData
   );

   modport master (
      output Core_Req, Core_WE, Core_Addr, Core_WData,
      output Ld_Req, Ld_WE, Ld_Lock, Ld_Addr, Ld_WData,
      output Mem_RData,
      input  Core_Stall, Core_RData, Core_RValid,
      input  Ld_Gnt, Ld_RData, Ld_RValid,
      input  Mem_En, Mem_WE, Mem_Addr, Mem_WData
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares one synchronous data RAM between the CPU MEM stage and an external
// loader. One access per cycle; ties go to whoever was not granted last.
// A loader holding Ld_Lock keeps the RAM for up to BURST_MAX consecutive
// grants, after which the core is guaranteed one slot.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - data_mem_arbiter_if.slave (core, loader and RAM signals)
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32,
   parameter int BURST_MAX = 8
) (
   input  logic                clk,
   input  logic                rst,
   data_mem_arbiter_if.slave   bus
);
   localparam int CNT_W = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   localparam logic [1:0] ST_ARB       = 2'd0;
   localparam logic [1:0] ST_LD_BURST  = 2'd1;
   localparam logic [1:0] ST_CORE_SLOT = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_gnt_q;   // 0 = core, 1 = loader
   logic             rd_valid_q;   // a granted read returns this cycle
   logic             owner_q;      // 0 = core, 1 = loader

   logic arb_core, arb_ld;
   logic core_win, ld_win;

   // Plain round-robin between the two requesters.
   assign arb_core = bus.Core_Req & (~bus.Ld_Req | last_gnt_q);
   assign arb_ld   = bus.Ld_Req & (~bus.Core_Req | ~last_gnt_q);

   always_comb begin
      core_win = 1'b0;
      ld_win   = 1'b0;
      state_d  = state_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_LD_BURST: begin
            if (bus.Ld_Req && bus.Ld_Lock) begin
               ld_win = 1'b1;
               cnt_d  = cnt_q + CNT_ONE;
               if (cnt_q + CNT_ONE == CNT_MAX) state_d = ST_CORE_SLOT;
            end else begin
               // Burst ends; this very cycle is arbitrated normally.
               core_win = arb_core;
               ld_win   = arb_ld;
               state_d  = ST_ARB;
               cnt_d    = '0;
            end
         end
         ST_CORE_SLOT: begin
            core_win = bus.Core_Req;
            ld_win   = ~bus.Core_Req & bus.Ld_Req;
            state_d  = ST_ARB;
            cnt_d    = '0;
         end
         default: begin
            core_win = arb_core;
            ld_win   = arb_ld;
            if (arb_ld && bus.Ld_Lock) begin
               cnt_d   = CNT_ONE;
               state_d = (CNT_ONE == CNT_MAX) ? ST_CORE_SLOT : ST_LD_BURST;
            end
         end
      endcase
      // Grants are combinational, so they must be suppressed while reset
      // is held rather than relying on the registered state alone.
      if (rst) begin
         core_win = 1'b0;
         ld_win   = 1'b0;
      end
   end

   assign bus.Ld_Gnt     = ld_win;
   assign bus.Core_Stall = bus.Core_Req & ~core_win;
   assign bus.Mem_En     = core_win | ld_win;
   assign bus.Mem_WE     = core_win ? bus.Core_WE    : (ld_win ? bus.Ld_WE    : 1'b0);
   assign bus.Mem_Addr   = core_win ? bus.Core_Addr  : (ld_win ? bus.Ld_Addr  : '0);
   assign bus.Mem_WData  = core_win ? bus.Core_WData : (ld_win ? bus.Ld_WData : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_ARB;
         cnt_q      <= '0;
         last_gnt_q <= 1'b1;
         rd_valid_q <= 1'b0;
         owner_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (core_win || ld_win) last_gnt_q <= ld_win;
         rd_valid_q <= (core_win & ~bus.Core_WE) | (ld_win & ~bus.Ld_WE);
         if ((core_win & ~bus.Core_WE) | (ld_win & ~bus.Ld_WE)) owner_q <= ld_win;
      end
   end

   // RAM data is routed only to the port whose read is returning.
   assign bus.Core_RValid = rd_valid_q & ~owner_q;
   assign bus.Ld_RValid   = rd_valid_q & owner_q;
   assign bus.Core_RData  = (rd_valid_q & ~owner_q) ? bus.Mem_RData : '0;
   assign bus.Ld_RData    = (rd_valid_q & owner_q)  ? bus.Mem_RData : '0;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed scenarios followed by random traffic, all checked cycle by cycle
// against a behavioural model of the arbitration rules and a shadow memory.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int BMAX = 8;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

   data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BMAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM seen by the arbiter.
   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic [DW-1:0] ram_rdata;
   assign bif.Mem_RData = ram_rdata;
   always @(posedge clk) begin
      if (bif.Mem_En) begin
         if (bif.Mem_WE) ram[bif.Mem_Addr] <= bif.Mem_WData;
         else            ram_rdata <= ram[bif.Mem_Addr];
      end
   end

   // Behavioural model state.
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   int       m_run;      // consecutive locked loader grants so far
   bit       m_slot;     // the core is owed its guaranteed slot now
   bit       m_last_ld;  // most recent grant went to the loader
   bit       p_core_v, p_ld_v;
   logic [DW-1:0] p_data;

   function automatic logic [DW-1:0] init_word(input int i);
      return 32'hA500_0000 ^ (i * 32'h0001_0103);
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_slot = 0; m_last_ld = 1;
      p_core_v = 0; p_ld_v = 0; p_data = '0;
   endtask

   // One arbitrated cycle: drive, check combinational and returning-read
   // outputs, then advance the model across the clock edge.
   task automatic cycle(input bit cr, input bit cwe, input logic [AW-1:0] ca, input logic [DW-1:0] cwd,
                        input bit lr, input bit lwe, input bit llk, input logic [AW-1:0] la,
                        input logic [DW-1:0] lwd, output bit obs_ld, output bit obs_stall);
      bit cw, lw, e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      @(negedge clk);
      bif.Core_Req = cr; bif.Core_WE = cwe; bif.Core_Addr = ca; bif.Core_WData = cwd;
      bif.Ld_Req = lr; bif.Ld_WE = lwe; bif.Ld_Lock = llk; bif.Ld_Addr = la; bif.Ld_WData = lwd;
      cw = 0; lw = 0;
      if (m_slot) begin
         cw = cr; lw = !cr && lr;
      end else if (m_run > 0 && lr && llk) begin
         lw = 1;
      end else if (cr && lr) begin
         if (m_last_ld) cw = 1; else lw = 1;
      end else begin
         cw = cr; lw = lr;
      end
      e_we   = cw ? cwe : (lw ? lwe : 1'b0);
      e_addr = cw ? ca  : (lw ? la  : '0);
      e_wd   = cw ? cwd : (lw ? lwd : '0);
      #1;
      chk("ld_gnt",     {31'b0, bif.Ld_Gnt},     {31'b0, lw});
      chk("core_stall", {31'b0, bif.Core_Stall}, {31'b0, cr && !cw});
      chk("mem_en",     {31'b0, bif.Mem_En},     {31'b0, cw || lw});
      chk("mem_we",     {31'b0, bif.Mem_WE},     {31'b0, e_we});
      chk("mem_addr",   {22'b0, bif.Mem_Addr},   {22'b0, e_addr});
      chk("mem_wdata",  bif.Mem_WData,           e_wd);
      chk("core_rvalid", {31'b0, bif.Core_RValid}, {31'b0, p_core_v});
      chk("ld_rvalid",   {31'b0, bif.Ld_RValid},   {31'b0, p_ld_v});
      chk("core_rdata",  bif.Core_RData, p_core_v ? p_data : '0);
      chk("ld_rdata",    bif.Ld_RData,   p_ld_v ? p_data : '0);
      obs_ld = bif.Ld_Gnt;
      obs_stall = bif.Core_Stall;
      $display("t=%0t core(req=%0b we=%0b a=%0d) ld(req=%0b we=%0b lk=%0b a=%0d) gnt_ld=%0b stall=%0b rv_c=%0b rv_l=%0b",
               $time, cr, cwe, ca, lr, lwe, llk, la, bif.Ld_Gnt, bif.Core_Stall, bif.Core_RValid, bif.Ld_RValid);
      @(posedge clk);
      p_core_v = cw && !cwe;
      p_ld_v   = lw && !lwe;
      if ((cw || lw) && !e_we) p_data = ref_mem[e_addr];
      if ((cw || lw) && e_we)  ref_mem[e_addr] = e_wd;
      if (cw || lw) m_last_ld = lw;
      if (m_slot) begin
         m_slot = 0; m_run = 0;
      end else if (lw && llk) begin
         m_run++;
         if (m_run == BMAX) begin m_slot = 1; m_run = 0; end
      end else begin
         m_run = 0;
      end
   endtask

   // Hold reset for n cycles (asserted between edges) with the core
   // requesting; everything but Core_Stall must read as zero.
   task automatic reset_phase(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rst = 1'b1;
         model_reset();
         bif.Core_Req = 1'b1; bif.Core_WE = 1'($urandom); bif.Core_Addr = AW'($urandom);
         bif.Core_WData = $urandom; bif.Ld_Req = 1'b1; bif.Ld_WE = 1'($urandom);
         bif.Ld_Lock = 1'b1; bif.Ld_Addr = AW'($urandom); bif.Ld_WData = $urandom;
         #1;
         chk("rst_ld_gnt",   {31'b0, bif.Ld_Gnt},      32'd0);
         chk("rst_stall",    {31'b0, bif.Core_Stall},  32'd1);
         chk("rst_mem_en",   {31'b0, bif.Mem_En},      32'd0);
         chk("rst_mem_we",   {31'b0, bif.Mem_WE},      32'd0);
         chk("rst_mem_addr", {22'b0, bif.Mem_Addr},    32'd0);
         chk("rst_mem_wd",   bif.Mem_WData,            32'd0);
         chk("rst_c_rvalid", {31'b0, bif.Core_RValid}, 32'd0);
         chk("rst_l_rvalid", {31'b0, bif.Ld_RValid},   32'd0);
         chk("rst_c_rdata",  bif.Core_RData,           32'd0);
         chk("rst_l_rdata",  bif.Ld_RData,             32'd0);
         $display("t=%0t reset held: stall=%0b mem_en=%0b rv_l=%0b", $time, bif.Core_Stall, bif.Mem_En, bif.Ld_RValid);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      bit gl, st;
      int pat030 [11];
      int pat029 [4];
      checks = 0;
      failures = 0;
      pat030 = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
      pat029 = '{0, 1, 0, 1};
      for (int i = 0; i < (1 << AW); i++) begin
         ram[i] = init_word(i);
         ref_mem[i] = init_word(i);
      end
      ram_rdata = '0;
      rst = 1'b1;
      bif.Core_Req = 0; bif.Core_WE = 0; bif.Core_Addr = '0; bif.Core_WData = '0;
      bif.Ld_Req = 0; bif.Ld_WE = 0; bif.Ld_Lock = 0; bif.Ld_Addr = '0; bif.Ld_WData = '0;
      model_reset();
      reset_phase(2);

      // Core-only read at address 5, then its data return.
      cycle(1, 0, 10'd5, 32'd0, 0, 0, 0, 10'd0, 32'd0, gl, st);
      chk("req028_stall", {31'b0, st}, 32'd0);
      cycle(0, 0, 10'd0, 32'd0, 0, 0, 0, 10'd0, 32'd0, gl, st);
      chk("req028_data", bif.Core_RData, init_word(5));

      // Simultaneous unlocked requests after reset alternate, core first.
      reset_phase(1);
      for (int i = 0; i < 4; i++) begin
         cycle(1, 0, 10'(i), 32'd0, 1, 0, 0, 10'(i + 100), 32'd0, gl, st);
         chk("req029_gnt", {31'b0, gl}, 32'(pat029[i]));
         chk("req029_stall", {31'b0, st}, 32'(pat029[i]));
      end

      // Locked burst: one core grant, BURST_MAX loader grants, core slot, ARB.
      reset_phase(1);
      for (int i = 0; i < 11; i++) begin
         cycle(1, 0, 10'(i + 200), 32'd0, 1, 0, 1, 10'(i + 300), 32'd0, gl, st);
         chk("req030_gnt", {31'b0, gl}, 32'(pat030[i]));
      end

      // Back-to-back alternating reads at 3 (core) and 7 (loader).
      reset_phase(1);
      for (int i = 0; i < 4; i++)
         cycle(1, 0, 10'd3, 32'd0, 1, 0, 0, 10'd7, 32'd0, gl, st);
      cycle(0, 0, 10'd0, 32'd0, 0, 0, 0, 10'd0, 32'd0, gl, st);

      // Reset in burst cycle 4 with a loader read in flight.
      reset_phase(1);
      for (int i = 0; i < 4; i++)
         cycle(0, 0, 10'd0, 32'd0, 1, 0, 1, 10'(i + 40), 32'd0, gl, st);
      reset_phase(1);
      cycle(1, 0, 10'd9, 32'd0, 1, 0, 0, 10'd10, 32'd0, gl, st);
      chk("req032_core_tie", {31'b0, gl}, 32'd0);

      // Random traffic on a small address window so reads see earlier writes.
      for (int i = 0; i < 600; i++) begin
         cycle(1'($urandom_range(0, 99) < 60), 1'($urandom), 10'($urandom_range(0, 15)), $urandom,
               1'($urandom_range(0, 99) < 80), 1'($urandom), 1'($urandom_range(0, 99) < 85),
               10'($urandom_range(0, 15)), $urandom, gl, st);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
